pe_accumulator: RTL and testbench

Consumer stage for the processing-element array: takes the registered per-cycle products of LANES PEs, sums them across lanes and over a programmed number of beats, then requantizes the sum to DATA_WIDTH with a rounding right-shift and unsigned saturation. It sits directly downstream of the PE row. It returns one result per dot-product over a valid/ready output handshake. Upstream control aligns in_valid with the PEs' one-cycle product latency.

---
 rtl/pe_pkg.sv | 19 +
 rtl/lane_adder_tree.sv | 31 +++
 rtl/pe_accumulator.sv | 159 +++++++++++++++
 tb/tb_pe_accumulator.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and sizing helpers for the PE-row accumulator slice.
package pe_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    REQUANT = 2'd2,
    HOLD    = 2'd3
  } acc_state_t;

  // Width of one beat's cross-lane sum without loss.
  function automatic int unsigned lane_sum_width(input int unsigned data_width,
                                                 input int unsigned lanes);
    return data_width + 32'($clog2(lanes));
  endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational pairwise adder tree summing LANES unsigned PE products.
module lane_adder_tree
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LANES      = 4
) (
  input  logic [LANES*DATA_WIDTH-1:0]                   i_data,
  output logic [lane_sum_width(DATA_WIDTH, LANES)-1:0] o_sum_c
);

  localparam int unsigned SUM_W  = lane_sum_width(DATA_WIDTH, LANES);
  localparam int unsigned LEVELS = 32'($clog2(LANES));
  localparam int unsigned NODES  = 32'(1) << LEVELS;

  logic [SUM_W-1:0] w_node [NODES];

  // Leaves padded to a power of two; each level folds pairs into the lower half.
  always_comb begin
    for (int unsigned n = 0; n < NODES; n++) begin
      w_node[n] = (n < LANES) ? SUM_W'(i_data[n*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end
    for (int unsigned w = NODES / 2; w > 0; w = w / 2) begin
      for (int unsigned i = 0; i < w; i++) begin
        w_node[i] = w_node[2*i] + w_node[2*i+1];
      end
    end
    o_sum_c = w_node[0];
  end

endmodule

// File: rtl/pe_accumulator.sv
// Sums PE-row products across lanes and over a programmed beat count, then
// requantizes with a rounding right-shift and unsigned saturation.
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [LEN_WIDTH-1:0]        i_len,
  input  logic [4:0]                  i_shift,
  input  logic                        i_in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] i_in_data,
  output logic                        o_in_ready,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_WIDTH-1:0]       o_out_data,
  output logic [ACC_WIDTH-1:0]        o_out_raw,
  output logic                        o_overflow,
  output logic                        o_busy
);

  localparam int unsigned SUM_W   = lane_sum_width(DATA_WIDTH, LANES);
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned RND_W   = ACC_WIDTH + 1;

  acc_state_t             r_state;
  acc_state_t             w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [SHIFT_W-1:0]     r_shift;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [ACC_WIDTH-1:0]   r_out_raw;
  logic                   r_overflow;
  logic                   r_busy;

  logic [SUM_W-1:0]       w_lane_sum;
  logic [RND_W-1:0]       w_acc_sum;
  logic                   w_acc_ovf;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic                   w_start;
  logic                   w_beat;
  logic                   w_last_beat;
  logic                   w_out_fire;
  logic [RND_W-1:0]       w_bias;
  logic [RND_W-1:0]       w_rounded;
  logic [DATA_WIDTH-1:0]  w_requant;
  logic                   w_in_ready_nxt;
  logic                   w_out_valid_nxt;
  logic                   w_busy_nxt;

  lane_adder_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_lane_adder_tree (
    .i_data  (i_in_data),
    .o_sum_c (w_lane_sum)
  );

  // r_in_ready mirrors state==ACCUM, so it doubles as the beat qualifier.
  assign w_start     = (r_state == IDLE) && i_start;
  assign w_beat      = r_in_ready && i_in_valid;
  assign w_last_beat = w_beat && (r_cnt == LEN_WIDTH'(1));
  assign w_out_fire  = r_out_valid && i_out_ready;

  // One spare MSB catches accumulator overflow so it can clamp to all-ones.
  assign w_acc_sum = {1'b0, r_acc} + RND_W'(w_lane_sum);
  assign w_acc_ovf = w_acc_sum[ACC_WIDTH];
  assign w_acc_nxt = w_acc_ovf ? '1 : w_acc_sum[ACC_WIDTH-1:0];

  // Round-half-up shift at ACC_WIDTH+1 bits, then clamp to DATA_WIDTH.
  assign w_bias    = (r_shift == '0) ? '0 : (RND_W'(1) << (r_shift - SHIFT_W'(1)));
  assign w_rounded = ({1'b0, r_acc} + w_bias) >> r_shift;
  assign w_requant = (|w_rounded[RND_W-1:DATA_WIDTH]) ? '1 : w_rounded[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = (i_len == '0) ? REQUANT : ACCUM;
      ACCUM:   if (w_last_beat) w_state_nxt = REQUANT;
      REQUANT: w_state_nxt = HOLD;
      HOLD:    if (w_out_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    case (w_state_nxt)
      ACCUM: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      REQUANT: w_busy_nxt = 1'b1;
      HOLD: begin
        w_out_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_overflow  <= 1'b0;
      r_out_data  <= '0;
      r_out_raw   <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      if (w_start) begin
        r_cnt      <= i_len;
        r_shift    <= i_shift;
        r_acc      <= '0;
        r_overflow <= 1'b0;
      end else if (w_beat) begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
        r_acc <= w_acc_nxt;
        if (w_acc_ovf) r_overflow <= 1'b1;
      end
      if (r_state == REQUANT) begin
        r_out_data <= w_requant;
        r_out_raw  <= r_acc;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_raw   = r_out_raw;
  assign o_overflow  = r_overflow;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_pe_accumulator.sv
// Scoreboard bench for pe_accumulator: a wide-accumulator instance plus a
// 12-bit-accumulator instance sharing one stimulus stream.
module tb_pe_accumulator;
  import pe_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 24;
  localparam int unsigned AW_S  = 12;
  localparam int unsigned LW    = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] raw;
    logic          ovf;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_start;
  logic [LW-1:0]         i_len;
  logic [4:0]            i_shift;
  logic                  i_in_valid;
  logic [LANES*DW-1:0]   i_in_data;
  logic                  i_out_ready;
  logic                  o_in_ready, o_out_valid, o_overflow, o_busy;
  logic [DW-1:0]         o_out_data;
  logic [AW-1:0]         o_out_raw;
  logic                  s_in_ready, s_out_valid, s_overflow, s_busy;
  logic [DW-1:0]         s_out_data;
  logic [AW_S-1:0]       s_out_raw;

  exp_t sb[$];
  exp_t sb_s[$];
  int   n_cmp;
  int   n_err;

  localparam logic [31:0] L1234 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] LFF   = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  pe_accumulator #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_shift(i_shift),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_raw(o_out_raw), .o_overflow(o_overflow), .o_busy(o_busy));

  pe_accumulator #(.DATA_WIDTH(DW), .LANES(LANES), .ACC_WIDTH(AW_S), .LEN_WIDTH(LW)) u_dut_s (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_shift(i_shift),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(s_in_ready),
    .o_out_valid(s_out_valid), .i_out_ready(i_out_ready), .o_out_data(s_out_data),
    .o_out_raw(s_out_raw), .o_overflow(s_overflow), .o_busy(s_busy));

  // Reference: saturating accumulate, round-half-up shift at aw+1 bits, clamp to 8 bits.
  function automatic exp_t model(input longint unsigned lane_sum, input int unsigned beats,
                                 input int unsigned sh, input int unsigned aw);
    longint unsigned acc;
    longint unsigned maxv;
    longint unsigned r;
    exp_t e;
    acc   = 0;
    maxv  = (64'd1 << aw) - 1;
    e.ovf = 1'b0;
    for (int b = 0; b < beats; b++) begin
      acc = acc + lane_sum;
      if (acc > maxv) begin
        acc   = maxv;
        e.ovf = 1'b1;
      end
    end
    if (sh == 0) r = acc;
    else r = ((acc + (64'd1 << (sh - 1))) & ((64'd1 << (aw + 1)) - 1)) >> sh;
    e.data = (r > 255) ? 8'hFF : DW'(r);
    e.raw  = AW'(acc);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int unsigned len, input int unsigned sh);
    i_start = 1'b1;
    i_len   = LW'(len);
    i_shift = 5'(sh);
    tick();
    i_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    i_in_valid = 1'b1;
    i_in_data  = d;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, inout int cyc, output bit ok);
    int n;
    n = 0;
    while (o_out_valid !== 1'b1 && n < limit) begin
      tick();
      cyc++;
      n++;
    end
    ok = (o_out_valid === 1'b1);
  endtask

  task automatic handshake();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_in_ready, o_out_valid, o_overflow, o_busy, o_out_data, o_out_raw} !== '0) begin
      n_err++;
      $display("FAIL reset_main: rdy=%0b vld=%0b ovf=%0b busy=%0b data=%0d raw=%0d expected all 0",
               o_in_ready, o_out_valid, o_overflow, o_busy, o_out_data, o_out_raw);
    end
    n_cmp++;
    if ({s_in_ready, s_out_valid, s_overflow, s_busy, s_out_data, s_out_raw} !== '0) begin
      n_err++;
      $display("FAIL reset_small: outputs not all zero (data=%0d raw=%0d)", s_out_data, s_out_raw);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    bit ok;
    exp_t e;
    start_op(3, 2);
    cyc = 1;
    n_cmp++;
    if (o_in_ready !== 1'b1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_accum_entry: in_ready=%0b busy=%0b expected 1/1", o_in_ready, o_busy);
    end
    for (int b = 0; b < 3; b++) begin
      beat(L1234);
      cyc++;
    end
    sb.push_back(model(10, 3, 2, AW));
    wait_valid(20, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 5) begin
      n_err++;
      $display("FAIL basic_latency: out_valid at cycle %0d (seen=%0b) expected 5", cyc, ok);
    end
    e = sb.pop_front();
    n_cmp++;
    if (o_out_data !== e.data || o_out_raw !== e.raw || o_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL basic_result: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               o_out_data, o_out_raw, o_overflow, e.data, e.raw, e.ovf);
    end
    handshake();
    n_cmp++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: busy=%0b out_valid=%0b expected 0/0", o_busy, o_out_valid);
    end
  endtask

  task automatic test_gaps();
    int cyc;
    int last;
    bit ok;
    exp_t e;
    start_op(3, 2);
    cyc  = 1;
    last = 0;
    for (int b = 0; b < 3; b++) begin
      last = cyc;
      beat(L1234);
      cyc++;
      if (b < 2) begin
        i_in_data = LFF;
        tick();
        cyc++;
      end
    end
    sb.push_back(model(10, 3, 2, AW));
    wait_valid(20, cyc, ok);
    n_cmp++;
    if (!ok || cyc != last + 2) begin
      n_err++;
      $display("FAIL gaps_latency: out_valid at cycle %0d (seen=%0b) expected %0d", cyc, ok, last + 2);
    end
    e = sb.pop_front();
    n_cmp++;
    if (o_out_data !== e.data || o_out_raw !== e.raw || o_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL gaps_result: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               o_out_data, o_out_raw, o_overflow, e.data, e.raw, e.ovf);
    end
    handshake();
  endtask

  task automatic test_out_sat();
    int cyc;
    bit ok;
    exp_t e;
    start_op(4, 0);
    cyc = 1;
    for (int b = 0; b < 4; b++) begin
      beat(LFF);
      cyc++;
    end
    sb.push_back(model(1020, 4, 0, AW));
    wait_valid(20, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 6) begin
      n_err++;
      $display("FAIL sat_latency: out_valid at cycle %0d (seen=%0b) expected 6", cyc, ok);
    end
    e = sb.pop_front();
    n_cmp++;
    if (o_out_data !== e.data || o_out_raw !== e.raw || o_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL sat_result: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               o_out_data, o_out_raw, o_overflow, e.data, e.raw, e.ovf);
    end
    handshake();
  endtask

  task automatic test_acc_overflow();
    int cyc;
    bit ok;
    exp_t e;
    start_op(5, 0);
    cyc = 1;
    for (int b = 0; b < 5; b++) begin
      beat(LFF);
      cyc++;
    end
    sb.push_back(model(1020, 5, 0, AW));
    sb_s.push_back(model(1020, 5, 0, AW_S));
    wait_valid(20, cyc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || o_out_data !== e.data || o_out_raw !== e.raw || o_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL ovf_wide_result: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               o_out_data, o_out_raw, o_overflow, e.data, e.raw, e.ovf);
    end
    e = sb_s.pop_front();
    n_cmp++;
    if (s_out_valid !== 1'b1 || s_out_data !== e.data || {12'd0, s_out_raw} !== e.raw ||
        s_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL ovf_small_result: vld=%0b data=%0d raw=%0d ovf=%0b expected 1/%0d/%0d/%0b",
               s_out_valid, s_out_data, s_out_raw, s_overflow, e.data, e.raw, e.ovf);
    end
    handshake();
    start_op(1, 0);
    n_cmp++;
    if (s_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear_on_start: overflow=%0b expected 0", s_overflow);
    end
    beat({8'd0, 8'd0, 8'd0, 8'd7});
    cyc = 3;
    sb_s.push_back(model(7, 1, 0, AW_S));
    sb.push_back(model(7, 1, 0, AW));
    wait_valid(20, cyc, ok);
    e = sb_s.pop_front();
    n_cmp++;
    if (!ok || s_out_data !== e.data || {12'd0, s_out_raw} !== e.raw || s_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL ovf_followup: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               s_out_data, s_out_raw, s_overflow, e.data, e.raw, e.ovf);
    end
    e = sb.pop_front();
    n_cmp++;
    if (o_out_data !== e.data || o_out_raw !== e.raw) begin
      n_err++;
      $display("FAIL ovf_followup_wide: data=%0d raw=%0d expected %0d/%0d",
               o_out_data, o_out_raw, e.data, e.raw);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    exp_t e;
    start_op(0, 0);
    cyc = 1;
    n_cmp++;
    if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_requant: busy=%0b in_ready=%0b expected 1/0", o_busy, o_in_ready);
    end
    sb.push_back(model(0, 0, 0, AW));
    wait_valid(20, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 2) begin
      n_err++;
      $display("FAIL zero_len_latency: out_valid at cycle %0d (seen=%0b) expected 2", cyc, ok);
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        i_start = 1'b1;
        i_len   = LW'(7);
      end
      tick();
      i_start = 1'b0;
      n_cmp++;
      if (o_out_valid !== 1'b1 || o_out_data !== e.data || o_out_raw !== e.raw ||
          o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: vld=%0b data=%0d raw=%0d busy=%0b expected 1/%0d/%0d/1",
                 k, o_out_valid, o_out_data, o_out_raw, o_busy, e.data, e.raw);
      end
    end
    handshake();
    n_cmp++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: busy=%0b out_valid=%0b expected 0/0", o_busy, o_out_valid);
    end
    start_op(1, 0);
    n_cmp++;
    if (o_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_restart: in_ready=%0b expected 1", o_in_ready);
    end
    beat({8'd0, 8'd0, 8'd0, 8'd9});
    cyc = 2;
    sb.push_back(model(9, 1, 0, AW));
    wait_valid(20, cyc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || o_out_data !== e.data || o_out_raw !== e.raw || cyc != 3) begin
      n_err++;
      $display("FAIL bp_restart_result: data=%0d raw=%0d cyc=%0d expected %0d/%0d/3",
               o_out_data, o_out_raw, cyc, e.data, e.raw);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    exp_t e;
    start_op(4, 0);
    beat(L1234);
    beat(L1234);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_in_ready, o_out_valid, o_overflow, o_busy, o_out_data, o_out_raw} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: rdy=%0b vld=%0b ovf=%0b busy=%0b data=%0d raw=%0d expected all 0",
               o_in_ready, o_out_valid, o_overflow, o_busy, o_out_data, o_out_raw);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: busy=%0b in_ready=%0b expected 0/0", o_busy, o_in_ready);
    end
    start_op(1, 0);
    beat({8'd0, 8'd0, 8'd0, 8'd5});
    cyc = 2;
    sb.push_back(model(5, 1, 0, AW));
    wait_valid(20, cyc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || o_out_data !== e.data || o_out_raw !== e.raw || o_overflow !== e.ovf) begin
      n_err++;
      $display("FAIL reset_mid_restart: data=%0d raw=%0d ovf=%0b expected %0d/%0d/%0b",
               o_out_data, o_out_raw, o_overflow, e.data, e.raw, e.ovf);
    end
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_len       = '0;
    i_shift     = '0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_out_sat();
    test_acc_overflow();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
